// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor: two PC lookup slots,
// the table write port from the execute stage, and the registered predictions.
interface branch_predictor_if #(
    parameter int IDX_W = 11,
    parameter int PC_W  = 13
);
    logic [PC_W-1:0]  pcF1;
    logic [PC_W-1:0]  pcF2;
    logic             stall;
    logic             predict_wen;
    logic [IDX_W-1:0] predict_w_addr;
    logic [15:0]      predict_w_data;
    logic             pred_taken1;
    logic [PC_W-1:0]  pred_target1;
    logic             pred_taken2;
    logic [PC_W-1:0]  pred_target2;
    logic             init_busy;

    modport master (
        output pcF1, pcF2, stall, predict_wen, predict_w_addr, predict_w_data,
        input  pred_taken1, pred_target1, pred_taken2, pred_target2, init_busy
    );

    modport slave (
        input  pcF1, pcF2, stall, predict_wen, predict_w_addr, predict_w_data,
        output pred_taken1, pred_target1, pred_taken2, pred_target2, init_busy
    );
endinterface

// File: rtl/branch_predictor.sv
// Dual-slot direct-mapped branch predictor: table cleared by a sweep after reset,
// one-cycle registered lookups with write-first bypass and stall hold.
module branch_predictor #(
    parameter int IDX_W = 11,
    parameter int PC_W  = 13
) (
    input  logic               CLK,
    input  logic               NRST,
    branch_predictor_if.slave  bus
);
    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] sweep_reg;
    logic             init_busy_reg;

    logic [15:0]      table_mem [2**IDX_W];
    logic             tbl_we;
    logic [IDX_W-1:0] tbl_waddr;
    logic [15:0]      tbl_wdata;
    logic             run_wen;
    logic [PC_W-1:0]  slot_pc [2];

    assign run_wen    = (state_reg == ST_RUN) && bus.predict_wen;
    assign slot_pc[0] = bus.pcF1;
    assign slot_pc[1] = bus.pcF2;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_reg     <= ST_INIT;
            sweep_reg     <= '0;
            init_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                ST_INIT: begin
                    sweep_reg <= sweep_reg + 1'b1;
                    if (sweep_reg == '1) begin
                        state_reg     <= ST_RUN;
                        init_busy_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_RUN;
            endcase
        end
    end

    // The sweep owns the write port during INIT, so execute-stage writes are dropped.
    always_comb begin
        tbl_we    = run_wen;
        tbl_waddr = bus.predict_w_addr;
        tbl_wdata = bus.predict_w_data;
        if (state_reg == ST_INIT) begin
            tbl_we    = 1'b1;
            tbl_waddr = sweep_reg;
            tbl_wdata = 16'h0000;
        end
    end

    always_ff @(posedge CLK) begin
        if (tbl_we) begin
            table_mem[tbl_waddr] <= tbl_wdata;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            logic [IDX_W-1:0] idx;
            logic [15:0]      entry_next;
            logic             taken_reg;
            logic [PC_W-1:0]  target_reg;
            logic             unused_bits;

            assign idx         = slot_pc[gi][IDX_W+1:2];
            assign unused_bits = ^{slot_pc[gi][1:0], entry_next[13]};
            // Write-first: a same-cycle write to this index wins over the stored entry.
            assign entry_next  = (run_wen && (idx == bus.predict_w_addr)) ?
                                 bus.predict_w_data : table_mem[idx];

            always_ff @(posedge CLK or negedge NRST) begin
                if (!NRST) begin
                    taken_reg  <= 1'b0;
                    target_reg <= '0;
                end else if (state_reg == ST_INIT) begin
                    taken_reg  <= 1'b0;
                    target_reg <= '0;
                end else if (!bus.stall) begin
                    taken_reg  <= entry_next[15] & entry_next[14];
                    target_reg <= PC_W'(entry_next[12:0]);
                end
            end
        end
    endgenerate

    assign bus.pred_taken1  = g_slot[0].taken_reg;
    assign bus.pred_target1 = g_slot[0].target_reg;
    assign bus.pred_taken2  = g_slot[1].taken_reg;
    assign bus.pred_target2 = g_slot[1].target_reg;
    assign bus.init_busy    = init_busy_reg;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: clear sweep timing, lookups, bypass,
// stall hold, INIT write drop and reset behaviour.
module tb_branch_predictor;
    logic CLK = 1'b0;
    logic NRST;
    int   checks = 0;
    int   errors = 0;

    branch_predictor_if #(.IDX_W(11), .PC_W(13)) bus ();

    branch_predictor #(.IDX_W(11), .PC_W(13)) dut (
        .CLK  (CLK),
        .NRST (NRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    task automatic do_write(input logic [10:0] addr, input logic [15:0] data);
        @(negedge CLK);
        bus.predict_wen    = 1'b1;
        bus.predict_w_addr = addr;
        bus.predict_w_data = data;
        @(negedge CLK);
        bus.predict_wen    = 1'b0;
        $display("write addr=%h data=%h", addr, data);
    endtask

    // Drive both PCs at a negedge; outputs are valid at the following negedge.
    task automatic do_read(input logic [12:0] pc1, input logic [12:0] pc2);
        bus.pcF1 = pc1;
        bus.pcF2 = pc2;
        @(negedge CLK);
        $display("read pc1=%h pc2=%h -> t1=%b tg1=%h t2=%b tg2=%h", pc1, pc2,
                 bus.pred_taken1, bus.pred_target1, bus.pred_taken2, bus.pred_target2);
    endtask

    // Counts edges until init_busy drops (bounded), noting any nonzero prediction.
    task automatic wait_sweep(output int n, output int nonzero);
        n = 0;
        nonzero = 0;
        while (n < 4096) begin
            @(posedge CLK);
            #1;
            n++;
            if (bus.pred_taken1 !== 1'b0 || bus.pred_taken2 !== 1'b0 ||
                bus.pred_target1 !== 13'h0 || bus.pred_target2 !== 13'h0)
                nonzero++;
            if (bus.init_busy !== 1'b1) break;
        end
        $display("sweep edges=%0d nonzero_pred_cycles=%0d", n, nonzero);
    endtask

    task automatic test_reset;
        int n, nz;
        NRST = 1'b0;
        bus.pcF1 = 13'h0040; bus.pcF2 = 13'h0044; bus.stall = 1'b0;
        bus.predict_wen = 1'b0; bus.predict_w_addr = '0; bus.predict_w_data = '0;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.init_busy !== 1'b1) begin
            errors++; $display("FAIL reset_busy: got %b want 1", bus.init_busy);
        end
        checks++;
        if ({bus.pred_taken1, bus.pred_taken2, bus.pred_target1, bus.pred_target2} !== '0) begin
            errors++; $display("FAIL reset_outputs: got t1=%b tg1=%h t2=%b tg2=%h want all 0",
                                bus.pred_taken1, bus.pred_target1, bus.pred_taken2, bus.pred_target2);
        end
        NRST = 1'b1;
        wait_sweep(n, nz);
        checks++;
        if (n !== 2048) begin
            errors++; $display("FAIL sweep_length: got %0d edges want 2048", n);
        end
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL sweep_outputs_zero: got %0d nonzero cycles want 0", nz);
        end
        @(negedge CLK);
    endtask

    task automatic test_write_read;
        do_write(11'h010, 16'hC0A4);
        do_read(13'h0040, 13'h0000);
        checks++;
        if (bus.pred_taken1 !== 1'b1 || bus.pred_target1 !== 13'h00A4) begin
            errors++; $display("FAIL basic_read: got t=%b tg=%h want t=1 tg=00a4",
                                bus.pred_taken1, bus.pred_target1);
        end
    endtask

    task automatic test_slots;
        do_write(11'h020, 16'hA123);
        do_write(11'h021, 16'hDFFF);
        do_write(11'h022, 16'h6ABC);
        do_read(13'h0080, 13'h0087);
        checks++;
        if (bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h0123) begin
            errors++; $display("FAIL weak_counter_slot1: got t=%b tg=%h want t=0 tg=0123",
                                bus.pred_taken1, bus.pred_target1);
        end
        checks++;
        if (bus.pred_taken2 !== 1'b1 || bus.pred_target2 !== 13'h1FFF) begin
            errors++; $display("FAIL strong_counter_slot2: got t=%b tg=%h want t=1 tg=1fff",
                                bus.pred_taken2, bus.pred_target2);
        end
        do_read(13'h008A, 13'h0081);
        checks++;
        if (bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h0ABC) begin
            errors++; $display("FAIL invalid_entry_slot1: got t=%b tg=%h want t=0 tg=0abc",
                                bus.pred_taken1, bus.pred_target1);
        end
        checks++;
        if (bus.pred_taken2 !== 1'b0 || bus.pred_target2 !== 13'h0123) begin
            errors++; $display("FAIL low_bits_ignored_slot2: got t=%b tg=%h want t=0 tg=0123",
                                bus.pred_taken2, bus.pred_target2);
        end
    endtask

    task automatic test_bypass;
        bus.predict_wen    = 1'b1;
        bus.predict_w_addr = 11'h010;
        bus.predict_w_data = 16'h9088;
        do_read(13'h0040, 13'h0040);
        bus.predict_wen = 1'b0;
        checks++;
        if (bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h1088) begin
            errors++; $display("FAIL bypass_slot1: got t=%b tg=%h want t=0 tg=1088",
                                bus.pred_taken1, bus.pred_target1);
        end
        checks++;
        if (bus.pred_taken2 !== 1'b0 || bus.pred_target2 !== 13'h1088) begin
            errors++; $display("FAIL bypass_slot2: got t=%b tg=%h want t=0 tg=1088",
                                bus.pred_taken2, bus.pred_target2);
        end
    endtask

    task automatic test_stall;
        do_read(13'h0000, 13'h0040);
        checks++;
        if (bus.pred_taken2 !== 1'b0 || bus.pred_target2 !== 13'h1088) begin
            errors++; $display("FAIL stall_latch: got t=%b tg=%h want t=0 tg=1088",
                                bus.pred_taken2, bus.pred_target2);
        end
        bus.stall          = 1'b1;
        bus.predict_wen    = 1'b1;
        bus.predict_w_addr = 11'h010;
        bus.predict_w_data = 16'hE010;
        for (int c = 0; c < 3; c++) begin
            do_read(13'h0084, 13'h0040);
            checks++;
            if (bus.pred_taken2 !== 1'b0 || bus.pred_target2 !== 13'h1088 ||
                bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h0000) begin
                errors++; $display("FAIL stall_hold cycle %0d: got t1=%b tg1=%h t2=%b tg2=%h want 0 0000 0 1088",
                                    c, bus.pred_taken1, bus.pred_target1, bus.pred_taken2, bus.pred_target2);
            end
        end
        bus.stall       = 1'b0;
        bus.predict_wen = 1'b0;
        do_read(13'h0084, 13'h0040);
        checks++;
        if (bus.pred_taken2 !== 1'b1 || bus.pred_target2 !== 13'h0010) begin
            errors++; $display("FAIL stall_release_slot2: got t=%b tg=%h want t=1 tg=0010",
                                bus.pred_taken2, bus.pred_target2);
        end
        checks++;
        if (bus.pred_taken1 !== 1'b1 || bus.pred_target1 !== 13'h1FFF) begin
            errors++; $display("FAIL stall_release_slot1: got t=%b tg=%h want t=1 tg=1fff",
                                bus.pred_taken1, bus.pred_target1);
        end
    endtask

    task automatic test_init_drop;
        int n, nz;
        @(negedge CLK);
        NRST = 1'b0;
        bus.pcF1 = 13'h0014; bus.pcF2 = 13'h0014;
        @(negedge CLK);
        NRST = 1'b1;
        bus.predict_wen    = 1'b1;
        bus.predict_w_addr = 11'h005;
        bus.predict_w_data = 16'hFFFF;
        repeat (100) @(negedge CLK);
        NRST = 1'b0;
        #1;
        checks++;
        if (bus.init_busy !== 1'b1) begin
            errors++; $display("FAIL midsweep_reset_busy: got %b want 1", bus.init_busy);
        end
        @(negedge CLK);
        NRST = 1'b1;
        wait_sweep(n, nz);
        bus.predict_wen = 1'b0;
        checks++;
        if (n !== 2048) begin
            errors++; $display("FAIL resweep_length: got %0d edges want 2048", n);
        end
        checks++;
        if (nz !== 0) begin
            errors++; $display("FAIL init_outputs_zero: got %0d nonzero cycles want 0", nz);
        end
        @(negedge CLK);
        do_read(13'h0014, 13'h0014);
        checks++;
        if (bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h0000) begin
            errors++; $display("FAIL init_write_dropped: got t=%b tg=%h want t=0 tg=0000",
                                bus.pred_taken1, bus.pred_target1);
        end
    endtask

    task automatic test_reset_mid_run;
        int n, nz;
        do_write(11'h030, 16'hC555);
        do_read(13'h00C0, 13'h00C0);
        checks++;
        if (bus.pred_taken1 !== 1'b1 || bus.pred_target1 !== 13'h0555) begin
            errors++; $display("FAIL pre_reset_read: got t=%b tg=%h want t=1 tg=0555",
                                bus.pred_taken1, bus.pred_target1);
        end
        #2;
        NRST = 1'b0;
        #1;
        checks++;
        if (bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h0 ||
            bus.pred_taken2 !== 1'b0 || bus.pred_target2 !== 13'h0 || bus.init_busy !== 1'b1) begin
            errors++; $display("FAIL async_reset: got t1=%b tg1=%h t2=%b tg2=%h busy=%b want 0 0000 0 0000 1",
                                bus.pred_taken1, bus.pred_target1, bus.pred_taken2, bus.pred_target2, bus.init_busy);
        end
        @(negedge CLK);
        NRST = 1'b1;
        wait_sweep(n, nz);
        checks++;
        if (n !== 2048) begin
            errors++; $display("FAIL run_reset_sweep_length: got %0d edges want 2048", n);
        end
        @(negedge CLK);
        do_read(13'h00C0, 13'h0084);
        checks++;
        if (bus.pred_taken1 !== 1'b0 || bus.pred_target1 !== 13'h0000 ||
            bus.pred_taken2 !== 1'b0 || bus.pred_target2 !== 13'h0000) begin
            errors++; $display("FAIL post_reset_cleared: got t1=%b tg1=%h t2=%b tg2=%h want all 0",
                                bus.pred_taken1, bus.pred_target1, bus.pred_taken2, bus.pred_target2);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_slots();
        test_bypass();
        test_stall();
        test_init_drop();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 11, sets the table index width (2**IDX_W entries).
REQ-002 Parameter PC_W, default 13, sets the byte-address PC width.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 NRST  input  1  reset, asynchronous, active-low.
REQ-005 pcF1  input  PC_W  fetch slot-1 PC (byte address).
REQ-006 pcF2  input  PC_W  fetch slot-2 PC (byte address).
REQ-007 stall  input  1  fetch stall; 1 holds the prediction outputs.
REQ-008 predict_wen  input  1  table write enable from the execute-stage PC calculator.
REQ-009 predict_w_addr  input  IDX_W  table write index.
REQ-010 predict_w_data  input  16  entry: [15] valid, [14:13] 2-bit saturating counter, [12:0] target PC.
REQ-011 pred_taken1  output  1  slot-1 predicted taken.
REQ-012 pred_target1  output  PC_W  slot-1 predicted target.
REQ-013 pred_taken2  output  1  slot-2 predicted taken.
REQ-014 pred_target2  output  PC_W  slot-2 predicted target.
REQ-015 init_busy  output  1  high while the table-clear sweep runs.

Function
REQ-016 Table SHALL hold 2**IDX_W 16-bit entries in the predict_w_data format; array storage has no reset of its own.
REQ-017 Read index SHALL be pc[IDX_W+1:2]; pc[1:0] are ignored.
REQ-018 States: INIT (clear sweep) and RUN; INIT is entered on reset.
REQ-019 In INIT, a sweep counter starting at 0 SHALL write entry[counter]=16'h0000 each cycle and increment by 1.
REQ-020 The cycle the counter writes index 2**IDX_W-1, state SHALL move to RUN and init_busy SHALL fall on that same edge (2048 cycles after reset release at the default).
REQ-021 In INIT, predict_wen writes SHALL be dropped, and pred_taken1/2 SHALL be 0 and pred_target1/2 SHALL be 0.
REQ-022 In RUN, with predict_wen=1, entry[predict_w_addr] SHALL be written with predict_w_data on the rising edge.
REQ-023 Read latency SHALL be one cycle: outputs registered on the edge at which pcF1/pcF2 are sampled.
REQ-024 Prediction: pred_takenN = valid & counter[1]; pred_targetN = entry[12:0] regardless of taken.
REQ-025 Same-cycle write/read to the same index SHALL be write-first: the registered output reflects predict_w_data, not the stale entry.
REQ-026 Both slots mapping to the same index SHALL receive identical predictions, including under bypass.
REQ-027 With stall=1, all four prediction outputs SHALL hold their values; table writes still proceed.
REQ-028 A write arriving during a stall to a held slot's index SHALL NOT alter that held output; the new value appears after stall falls and the index is re-read.
REQ-029 The counter field SHALL be stored as written; the block performs no counter arithmetic (saturation is the writer's duty).

Reset
REQ-030 NRST low SHALL asynchronously force pred_taken1/2=0, pred_target1/2=0, init_busy=1, state=INIT, sweep counter=0.
REQ-031 NRST asserted mid-sweep or mid-RUN SHALL restart the full sweep from index 0 after release.
REQ-032 No table entry SHALL be readable as valid before the sweep completes, whatever the power-up array contents.

Verification
REQ-033 Release NRST, count cycles -> init_busy=1 for exactly 2048 edges, then 0; pred_taken1/2=0 throughout.
REQ-034 RUN: write addr 11'h010 data 16'hC0A4, then pcF1=13'h0040 -> next cycle pred_taken1=1, pred_target1=13'h00A4.
REQ-035 RUN: write addr 11'h010 data 16'h9088 in the same cycle as pcF1=pcF2=13'h0040 -> next cycle both slots pred_taken=0, pred_target=13'h1088 (bypass, counter=00).
REQ-036 RUN: latch prediction for pcF2=13'h0040, raise stall 3 cycles while writing 16'hE010 to addr 11'h010 -> pred_target2 held; one cycle after stall falls, pred_taken2=1, pred_target2=13'h0010.
REQ-037 Assert predict_wen (addr 11'h005, data 16'hFFFF) during INIT, then finish sweep and read pcF1=13'h0014 -> pred_taken1=0, pred_target1=13'h0000.
REQ-038 Pull NRST low mid-RUN with valid entries present -> outputs 0 immediately, init_busy=1; after a full re-sweep, a read of a previously valid index returns pred_taken=0.
